// File: rtl/cpu_pkg.sv
// Shared types and widths for the 8-bit CPU control sequencer, its datapath and bench.
package cpu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ALU_OP_W = 4;

    // Instruction encodings carried on i_instr_op; 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_LDA  = 3'd0,
        OP_LDB  = 3'd1,
        OP_RDA  = 3'd2,
        OP_RDB  = 3'd3,
        OP_ALU  = 3'd4,
        OP_ALUI = 3'd5
    } instr_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_ALU  = 3'd3,
        S_TURN = 3'd4
    } seq_state_e;

endpackage

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 8-bit CPU datapath: accepts one instruction over
// valid/ready, generates register strobes, ALU controls and the databus drive,
// and returns read / ALU results captured off the bus.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned OP_W   = cpu_pkg::ALU_OP_W
) (
    input  logic              i_pld_clk,
    input  logic              i_pld_rstn,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [2:0]        i_instr_op,
    input  logic [DATA_W-1:0] i_instr_imm,
    input  logic [OP_W-1:0]   i_instr_aluop,
    input  logic              i_instr_cin,
    output logic              o_a_wrtn,
    output logic              o_a_rdn,
    output logic              o_b_wrtn,
    output logic              o_b_rdn,
    output logic [OP_W-1:0]   o_alu_opcode,
    output logic              o_cin,
    output logic              o_alu_sel,
    output logic              o_alu_flag_sel,
    inout  logic [DATA_W-1:0] io_databus,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_err
);

    seq_state_e        state_q, state_d;
    instr_op_e         op_q, op_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [OP_W-1:0]   aluop_q, aluop_d;
    logic              cin_q, cin_d;
    logic              alui_pend_q, alui_pend_d;

    logic              ready_q, ready_d;
    logic              a_wrtn_q, a_wrtn_d;
    logic              a_rdn_q, a_rdn_d;
    logic              b_wrtn_q, b_wrtn_d;
    logic              b_rdn_q, b_rdn_d;
    logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic              alu_cin_q, alu_cin_d;
    logic              alu_sel_q, alu_sel_d;
    logic              flag_sel_q, flag_sel_d;
    logic              bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic              accept;

    // Next-state logic; every output is derived from the next state so it
    // can be registered and change only on the rising edge.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        aluop_d     = aluop_q;
        cin_d       = cin_q;
        alui_pend_d = alui_pend_q;
        err_d       = 1'b0;
        accept      = (state_q == S_IDLE) && ready_q && i_instr_valid;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (instr_op_e'(i_instr_op))
                        OP_LDA, OP_LDB, OP_ALUI: state_d = S_WR;
                        OP_RDA, OP_RDB:          state_d = S_RD;
                        OP_ALU:                  state_d = S_ALU;
                        default:                 err_d   = 1'b1;
                    endcase
                    if (!err_d) begin
                        op_d        = instr_op_e'(i_instr_op);
                        imm_d       = i_instr_imm;
                        aluop_d     = i_instr_aluop;
                        cin_d       = i_instr_cin;
                        alui_pend_d = (instr_op_e'(i_instr_op) == OP_ALUI);
                    end
                end
            end
            S_WR, S_RD, S_ALU: state_d = S_TURN;
            S_TURN: begin
                if (alui_pend_q) begin
                    state_d     = S_ALU;
                    alui_pend_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d    = (state_d == S_IDLE);
        a_wrtn_d   = !((state_d == S_WR) && (op_d == OP_LDA));
        b_wrtn_d   = !((state_d == S_WR) && ((op_d == OP_LDB) || (op_d == OP_ALUI)));
        a_rdn_d    = !((state_d == S_RD) && (op_d == OP_RDA));
        b_rdn_d    = !((state_d == S_RD) && (op_d == OP_RDB));
        alu_sel_d  = (state_d == S_ALU);
        flag_sel_d = (state_d == S_ALU);
        bus_oe_d   = (state_d == S_WR);
        bus_out_d  = imm_d;

        // Opcode and carry-in are sticky; only alu_sel/flag_sel gate their effect.
        alu_opcode_d = (state_d == S_ALU) ? aluop_d : alu_opcode_q;
        alu_cin_d    = (state_d == S_ALU) ? cin_d   : alu_cin_q;

        // Result is taken off the bus on the edge that leaves RD or ALU.
        rd_valid_d = (state_d == S_TURN) && ((state_q == S_RD) || (state_q == S_ALU));
        rd_data_d  = ((state_q == S_RD) || (state_q == S_ALU)) ? io_databus : rd_data_q;
    end

    // State, latched instruction and registered outputs with synchronous reset.
    always_ff @(posedge i_pld_clk) begin
        if (!i_pld_rstn) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LDA;
            imm_q        <= '0;
            aluop_q      <= '0;
            cin_q        <= 1'b0;
            alui_pend_q  <= 1'b0;
            ready_q      <= 1'b0;
            a_wrtn_q     <= 1'b1;
            a_rdn_q      <= 1'b1;
            b_wrtn_q     <= 1'b1;
            b_rdn_q      <= 1'b1;
            alu_opcode_q <= '0;
            alu_cin_q    <= 1'b0;
            alu_sel_q    <= 1'b0;
            flag_sel_q   <= 1'b0;
            bus_oe_q     <= 1'b0;
            bus_out_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            imm_q        <= imm_d;
            aluop_q      <= aluop_d;
            cin_q        <= cin_d;
            alui_pend_q  <= alui_pend_d;
            ready_q      <= ready_d;
            a_wrtn_q     <= a_wrtn_d;
            a_rdn_q      <= a_rdn_d;
            b_wrtn_q     <= b_wrtn_d;
            b_rdn_q      <= b_rdn_d;
            alu_opcode_q <= alu_opcode_d;
            alu_cin_q    <= alu_cin_d;
            alu_sel_q    <= alu_sel_d;
            flag_sel_q   <= flag_sel_d;
            bus_oe_q     <= bus_oe_d;
            bus_out_q    <= bus_out_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
        end
    end

    assign io_databus     = bus_oe_q ? bus_out_q : {DATA_W{1'bz}};

    assign o_instr_ready  = ready_q;
    assign o_a_wrtn       = a_wrtn_q;
    assign o_a_rdn        = a_rdn_q;
    assign o_b_wrtn       = b_wrtn_q;
    assign o_b_rdn        = b_rdn_q;
    assign o_alu_opcode   = alu_opcode_q;
    assign o_cin          = alu_cin_q;
    assign o_alu_sel      = alu_sel_q;
    assign o_alu_flag_sel = flag_sel_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = rd_data_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq with a behavioural A/B/ALU/flags datapath
// that drives the shared bus from the read strobes and alu_sel.
module tb_cpu_ctrl_seq;
    import cpu_pkg::*;

    localparam int unsigned DW = DATA_W;
    localparam int unsigned OW = ALU_OP_W;

    localparam logic [OW-1:0] ALU_ADD = 4'h0;
    localparam logic [OW-1:0] ALU_OR  = 4'h1;
    localparam logic [OW-1:0] ALU_AND = 4'h2;
    localparam logic [OW-1:0] ALU_XOR = 4'h3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid = 1'b0;
    logic [2:0]    op = '0;
    logic [DW-1:0] imm = '0;
    logic [OW-1:0] aluop = '0;
    logic          cin = 1'b0;

    logic          ready, a_wrtn, a_rdn, b_wrtn, b_rdn, alu_cin, alu_sel, flag_sel;
    logic          rd_valid, err;
    logic [OW-1:0] alu_opcode;
    logic [DW-1:0] rd_data;
    wire  [DW-1:0] bus;

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.DATA_W(DW), .OP_W(OW)) dut (
        .i_pld_clk      (clk),
        .i_pld_rstn     (rstn),
        .i_instr_valid  (valid),
        .o_instr_ready  (ready),
        .i_instr_op     (op),
        .i_instr_imm    (imm),
        .i_instr_aluop  (aluop),
        .i_instr_cin    (cin),
        .o_a_wrtn       (a_wrtn),
        .o_a_rdn        (a_rdn),
        .o_b_wrtn       (b_wrtn),
        .o_b_rdn        (b_rdn),
        .o_alu_opcode   (alu_opcode),
        .o_cin          (alu_cin),
        .o_alu_sel      (alu_sel),
        .o_alu_flag_sel (flag_sel),
        .io_databus     (bus),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data),
        .o_err          (err)
    );

    // Datapath model
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    logic          flag_c = 1'b0;
    int            flag_upd = 0;
    logic [DW:0]   alu_res;
    logic          dp_oe;
    logic [DW-1:0] dp_val;
    logic          probe_oe = 1'b0;

    always_comb begin
        case (alu_opcode)
            ALU_ADD: alu_res = {1'b0, reg_a} + {1'b0, reg_b} + {{DW{1'b0}}, alu_cin};
            ALU_OR:  alu_res = {1'b0, reg_a | reg_b};
            ALU_AND: alu_res = {1'b0, reg_a & reg_b};
            ALU_XOR: alu_res = {1'b0, reg_a ^ reg_b};
            default: alu_res = '0;
        endcase
        dp_oe  = !a_rdn || !b_rdn || alu_sel;
        dp_val = !a_rdn ? reg_a : (!b_rdn ? reg_b : alu_res[DW-1:0]);
    end

    assign bus = dp_oe    ? dp_val : {DW{1'bz}};
    assign bus = probe_oe ? '0     : {DW{1'bz}};

    always @(posedge clk) begin
        if (!a_wrtn) reg_a <= bus;
        if (!b_wrtn) reg_b <= bus;
        if (flag_sel) begin
            flag_c   <= alu_res[DW];
            flag_upd <= flag_upd + 1;
        end
    end

    // Scoreboard
    typedef struct {
        bit            is_err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   strobe_cnt = 0;
    int   alu_run = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Monitor: pops expected responses and watches strobe/bus rules each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid || err) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, rd_valid, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_kind_err", {31'd0, err}, {31'd0, e.is_err});
                if (!e.is_err) chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
            end
        end
        if (alu_sel) begin
            alu_run++;
        end else if (alu_run != 0) begin
            chk("alu_sel_width", alu_run, 1);
            alu_run = 0;
        end
        if (alu_sel || flag_sel) chk("flag_sel_eq_alu_sel", {31'd0, flag_sel}, {31'd0, alu_sel});
        if (!a_wrtn || !b_wrtn || !a_rdn || !b_rdn || alu_sel || flag_sel) strobe_cnt++;
        if (!a_wrtn || !b_wrtn || !a_rdn || !b_rdn || alu_sel)
            chk("strobe_onehot",
                {31'd0, ($countones({~a_wrtn, ~b_wrtn, ~a_rdn, ~b_rdn, alu_sel}) <= 1)}, 32'd1);
        if (dp_oe) chk("bus_single_driver", {24'd0, bus}, {24'd0, dp_val});
    end

    // Issue one instruction; returns at a negedge once ready reappears.
    task automatic issue(input logic [2:0] i_op, input logic [DW-1:0] i_imm,
                         input logic [OW-1:0] i_aop, input logic i_c, input int lat,
                         input bit keep, input bit has_exp, input bit exp_err,
                         input logic [DW-1:0] exp_data);
        int n;
        exp_t e;
        valid = 1'b1;
        op    = i_op;
        imm   = i_imm;
        aluop = i_aop;
        cin   = i_c;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("accept_timeout", {31'd0, ready}, 32'd1);
            valid = 1'b0;
            return;
        end
        if (has_exp) begin
            e.is_err = exp_err;
            e.data   = exp_data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) valid = 1'b0;
        if (lat > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ready && n < 20);
            chk("ready_gap", n, lat);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic check_bus_released(input string name);
        probe_oe = 1'b1;
        #1;
        chk(name, {24'd0, bus}, 32'd0);
        probe_oe = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_strobes"}, {28'd0, a_wrtn, a_rdn, b_wrtn, b_rdn}, 32'hF);
        chk({pfx, "_alu_sel"}, {30'd0, alu_sel, flag_sel}, 32'd0);
        chk({pfx, "_rd_valid_err"}, {30'd0, rd_valid, err}, 32'd0);
        chk({pfx, "_ready"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        int s0, n;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_alu_opcode_cin", {27'd0, alu_opcode, alu_cin}, 32'd0);
        chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
        check_bus_released("reset_bus_z");
        rstn = 1'b1;
        @(negedge clk);

        // LDA 5A then RDA
        issue(3'd0, 8'h5A, ALU_ADD, 1'b0, 3, 0, 0, 0, 8'h00);
        chk("lda_captured_a", {24'd0, reg_a}, 32'h5A);
        issue(3'd2, 8'h00, ALU_ADD, 1'b0, 3, 0, 1, 0, 8'h5A);

        // 0F + 01 + 0
        issue(3'd0, 8'h0F, ALU_ADD, 1'b0, 3, 0, 0, 0, 8'h00);
        issue(3'd1, 8'h01, ALU_ADD, 1'b0, 3, 0, 0, 0, 8'h00);
        issue(3'd4, 8'h00, ALU_ADD, 1'b0, 3, 0, 1, 0, 8'h10);
        chk("add_carry_clear", {31'd0, flag_c}, 32'd0);

        // FF + ALUI 01 + 1
        issue(3'd0, 8'hFF, ALU_ADD, 1'b0, 3, 0, 0, 0, 8'h00);
        issue(3'd5, 8'h01, ALU_ADD, 1'b1, 5, 0, 1, 0, 8'h01);
        chk("alui_wrote_b", {24'd0, reg_b}, 32'h01);
        chk("alui_carry_set", {31'd0, flag_c}, 32'd1);

        // Illegal op 7
        s0 = strobe_cnt;
        issue(3'd7, 8'hA5, ALU_XOR, 1'b1, 1, 0, 1, 1, 8'h00);
        check_bus_released("illegal_bus_z");
        repeat (2) @(negedge clk);
        chk("illegal_no_strobe", strobe_cnt, s0);

        // Reset during the ALU cycle of an ALUI
        issue(3'd5, 8'h7E, ALU_ADD, 1'b0, 0, 0, 0, 0, 8'h00);
        n = 0;
        while (!alu_sel && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("alui_alu_phase_reached", {31'd0, alu_sel}, 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("abort");
        check_bus_released("abort_bus_z");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(3'd1, 8'h33, ALU_ADD, 1'b0, 3, 0, 0, 0, 8'h00);
        issue(3'd3, 8'h00, ALU_ADD, 1'b0, 3, 0, 1, 0, 8'h33);

        // Continuous valid, mixed instructions
        issue(3'd0, 8'h11, ALU_ADD, 1'b0, 3, 1, 0, 0, 8'h00);
        issue(3'd1, 8'h22, ALU_ADD, 1'b0, 3, 1, 0, 0, 8'h00);
        issue(3'd4, 8'h00, ALU_XOR, 1'b0, 3, 1, 1, 0, 8'h33);
        issue(3'd2, 8'h00, ALU_ADD, 1'b0, 3, 1, 1, 0, 8'h11);
        issue(3'd6, 8'h00, ALU_ADD, 1'b0, 1, 1, 1, 1, 8'h00);
        issue(3'd5, 8'h05, ALU_AND, 1'b0, 5, 0, 1, 0, 8'h01);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("flag_update_count", flag_upd, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Hardware control sequencer that drives the 8-bit CPU datapath: A/B registers, ALU, flags and shared databus. It accepts one instruction at a time over a valid/ready handshake. It then generates the register strobes, ALU controls and bus drive in place of the bench driver. Read and ALU results are captured off the databus and returned to the issuer.

## Interface
Parameters:
- DATA_W, 8, databus and immediate width
- OP_W, 4, ALU opcode width

Ports:
- i_pld_clk  in  1  system clock; all logic on rising edge
- i_pld_rstn  in  1  reset, synchronous, active-low
- i_instr_valid  in  1  instruction offered
- o_instr_ready  out  1  sequencer can accept (high only in IDLE)
- i_instr_op  in  3  0 LDA, 1 LDB, 2 RDA, 3 RDB, 4 ALU, 5 ALUI, 6–7 illegal
- i_instr_imm  in  DATA_W  immediate for LDA/LDB/ALUI
- i_instr_aluop  in  OP_W  ALU opcode for ALU/ALUI
- i_instr_cin  in  1  carry-in for ALU/ALUI
- o_a_wrtn, o_a_rdn, o_b_wrtn, o_b_rdn  out  1 each  active-low register write/read strobes
- o_alu_opcode  out  OP_W  ALU opcode to datapath
- o_cin  out  1  ALU carry-in
- o_alu_sel  out  1  ALU drives databus
- o_alu_flag_sel  out  1  flags update enable
- io_databus  inout  DATA_W  shared bus; driven only in WR state, else Z
- o_rd_valid  out  1  one-cycle pulse: o_rd_data valid
- o_rd_data  out  DATA_W  captured bus value
- o_err  out  1  one-cycle pulse on illegal op

## Operation
- Reset values: all *_wrtn/*_rdn = 1; o_alu_sel, o_alu_flag_sel, o_cin, o_rd_valid, o_err = 0; o_alu_opcode = 0; o_rd_data = 0; io_databus = Z; o_instr_ready = 0 while i_pld_rstn = 0.
- Instruction latched on the edge where valid && ready; all fields held internally until the instruction completes.
- FSM states: IDLE, WR, RD, ALU, TURN.
- IDLE -> WR for LDA/LDB/ALUI.
- IDLE -> RD for RDA/RDB.
- IDLE -> ALU for ALU.
- IDLE -> IDLE for illegal ops, with o_err pulsed the next cycle and no strobes.
- WR: drive imm on bus; assert a_wrtn (LDA) or b_wrtn (LDB, ALUI). WR -> TURN.
- RD: assert a_rdn or b_rdn; bus sampled into o_rd_data on the edge leaving RD. RD -> TURN.
- ALU: o_alu_opcode/o_cin = latched values, alu_sel = flag_sel = 1 for exactly one cycle; bus sampled into o_rd_data on the edge leaving ALU. ALU -> TURN.
- TURN: all strobes deasserted, bus Z, o_rd_valid = 1 if the previous state was RD or ALU.
- TURN -> ALU if an ALUI is pending its ALU phase, else TURN -> IDLE.
- o_alu_opcode and o_cin hold their last value outside ALU; only alu_sel/flag_sel gate the effect.
- Never more than one bus driver: the sequencer drives only in WR, and TURN separates every drive/read/ALU phase.

## Timing
- All outputs registered; strobes change on rising edge only.
- Write strobes are stable for the full cycle, giving the datapath one full cycle of setup.
- Accept at edge k:
  - LDx: wrtn low cycle k+1; ready high again at cycle k+3.
  - RDx/ALU: strobe cycle k+1, o_rd_valid cycle k+2, ready at k+3.
  - ALUI: WR k+1, TURN k+2, ALU k+3, TURN + o_rd_valid k+4, ready k+5.
  - Illegal: o_err k+1, ready k+1.
- Throughput: one instruction per 3 cycles (ALUI 5). Back-to-back valid is accepted on the first IDLE cycle.
- The datapath must drive the bus combinationally from rdn/alu_sel within the same cycle.
- Reset mid-operation aborts at the next edge: FSM to IDLE, pending ALUI cleared, strobes to reset values, no o_rd_valid for the aborted instruction.
- Flags update exactly once per ALU/ALUI, because flag_sel is a single-cycle pulse.

## Structure
- Package cpu_pkg:
  - instr_op_e (LDA..ALUI)
  - seq_state_e (IDLE, WR, RD, ALU, TURN)
  - DATA_W and ALU_OP_W constants, shared with the datapath and bench
- Single module; the tri-state bus driver is one continuous assign from internal bus_oe/bus_out, so no sub-module.

## Test plan
- LDA imm 8'h5A, then RDA -> a_wrtn low one cycle with bus = 5A; o_rd_valid pulse, o_rd_data = 8'h5A; ready gaps of 2 cycles each.
- LDA 8'h0F, LDB 8'h01, ALU op ADD, cin 0 -> alu_sel/flag_sel high exactly one cycle; o_rd_data = 8'h10.
- LDA 8'hFF, ALUI imm 8'h01, op ADD, cin 1 -> b_wrtn pulse with bus 01; TURN; ALU phase; o_rd_data = 8'h01 (carry out in flags); ready returns 5 cycles after accept.
- Op 7 issued -> o_err single pulse, no strobe or bus activity, ready stays high.
- Reset asserted during the ALU cycle of an ALUI -> all strobes deasserted next edge, bus Z, no o_rd_valid; after release, LDB 8'h33 completes normally.
- Continuous valid with 6 mixed instructions -> each accepted only in IDLE; bus is never driven while any rdn low or alu_sel high (bench assertion).
